test_seq_ctrl: RTL and testbench
================================

TEST_SEQ_CTRL -- requirements
Module: test_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of step-table entries (power of two, 2..16).
REQ-002 Parameter DWELL_W, default 8, SHALL set the dwell-count width per step.
REQ-003 inClock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 inReset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 inWrEn  input  1  SHALL qualify a step-table write.
REQ-006 inWrAddr  input  log2(DEPTH)  SHALL give the table entry to write.
REQ-007 inWrData  input  17+DWELL_W  SHALL carry the entry: [16:14] sel1, [13:11] sel2, [10] sel3, [9:8] sel6, [7:6] sel9, [5] sel11, [4] sel12, [3:1] sel15, [0] sel17, [17+DWELL_W-1:17] dwell.
REQ-008 inLastStep  input  log2(DEPTH)  SHALL give the index of the last step run; sampled on accepted start.
REQ-009 inStart  input  1  SHALL request a sequence run.
REQ-010 inLoop  input  1  SHALL, when sampled high on accepted start, make the sequence repeat until abort.
REQ-011 inAbort  input  1  SHALL terminate any run.
REQ-012 outSEL1, outSEL2  output  3 each; outSEL3  output  1; outSEL6, outSEL9  output  2 each; outSEL11, outSEL12  output  1 each; outSEL15  output  3; outSEL17  output  1  SHALL drive the test mux/demux selects, all registered.
REQ-013 outBusy  output  1  SHALL be high in any state except IDLE.
REQ-014 outStep  output  log2(DEPTH)  SHALL give the current step index.
REQ-015 outStepStrobe  output  1  SHALL pulse one cycle on the first cycle a step's selects are applied.
REQ-016 outDone  output  1  SHALL pulse one cycle when a non-loop run completes.
REQ-017 outError  output  1  SHALL pulse one cycle on a rejected write or start.

Function
REQ-018 FSM states SHALL be IDLE, GUARD, DWELL and FINISH.
REQ-019 IDLE: inStart high and inAbort low SHALL latch inLastStep and inLoop, set step=0 and go to GUARD.
REQ-020 GUARD SHALL last exactly 1 cycle with all sel outputs 0 (break-before-make), then go to DWELL.
REQ-021 Entry to DWELL SHALL drive the sel outputs with table[step] and pulse outStepStrobe.
REQ-022 Selects SHALL be held for max(dwell,1) cycles, with dwell=0 treated as 1.
REQ-023 End of DWELL with step<last SHALL increment step and go to GUARD.
REQ-024 End of DWELL with step==last SHALL, if looping, set step=0 and go to GUARD; otherwise go to FINISH.
REQ-025 FINISH SHALL last 1 cycle with sel=0 and outDone=1, then go to IDLE.
REQ-026 Latency: start accepted at cycle N SHALL give GUARD at N+1 and step-0 selects at N+2.
REQ-027 inAbort SHALL have priority in every state: next state IDLE, sel=0, step=0, no outDone.
REQ-028 inAbort and inStart high together in IDLE SHALL leave the block in IDLE with no error.
REQ-029 A write while outBusy SHALL be ignored and pulse outError; a write in IDLE SHALL update the entry on the next edge.
REQ-030 inStart while outBusy SHALL be ignored and pulse outError.
REQ-031 inLastStep ≥ DEPTH cannot occur by width; step SHALL wrap modulo DEPTH only via the loop restart.
REQ-032 In IDLE all sel outputs SHALL be 0.

Reset
REQ-033 Reset SHALL put the FSM in IDLE and set all sel outputs, outStep, outBusy, outStepStrobe, outDone, outError and the dwell counter to 0.
REQ-034 Reset SHALL clear all table entries to 0; reset mid-run SHALL abort with no outDone pulse.

Structure
REQ-035 The shared package test_pkg SHALL hold the FSM state enum, the select-field bit positions and widths, and the packed step-entry struct.
REQ-036 The step table SHALL be one sub-module, test_step_ram: DEPTH x (17+DWELL_W), synchronous write, asynchronous read.

Verification
REQ-037 Load entry0 = sel1=5, dwell=3 and entry1 = sel9=2, dwell=0; last=1, start -> 1 guard, sel1=5 for 3 cycles, 1 guard, sel9=2 for 1 cycle, outDone pulse, IDLE.
REQ-038 Same table with inLoop=1 -> the step sequence 0,1,0,1 repeats, with an outStepStrobe on each step; inAbort mid-DWELL -> next cycle sel=0, outBusy=0, no outDone.
REQ-039 Write and start while busy -> outError pulses twice; the table and the run are unchanged.
REQ-040 Reset asserted in DWELL -> next cycle all outputs 0; a following start with the table still zero runs 1 guard + 1 dwell cycle per step.
REQ-041 Simultaneous inStart and inAbort in IDLE -> stays IDLE with outError=0.
REQ-042 DEPTH=8, last=7, all dwell=255 -> 8×256 busy cycles + FINISH; outStep counts 0..7.

Source files
------------

// File: rtl/test_pkg.sv
// test_pkg: shared FSM state enum, select-field layout and the select part of a step entry.
// A full step-table word is {dwell, step_sel_t}; dwell width is a parameter of the controller.
package test_pkg;
    typedef enum logic [1:0] {IDLE, GUARD, DWELL, FINISH} state_t;
    localparam int SEL_W     = 17;
    localparam int SEL1_POS  = 14, SEL1_W  = 3;
    localparam int SEL2_POS  = 11, SEL2_W  = 3;
    localparam int SEL3_POS  = 10, SEL3_W  = 1;
    localparam int SEL6_POS  = 8,  SEL6_W  = 2;
    localparam int SEL9_POS  = 6,  SEL9_W  = 2;
    localparam int SEL11_POS = 5,  SEL11_W = 1;
    localparam int SEL12_POS = 4,  SEL12_W = 1;
    localparam int SEL15_POS = 1,  SEL15_W = 3;
    localparam int SEL17_POS = 0,  SEL17_W = 1;
    typedef struct packed {
        logic [SEL1_W-1:0]  sel1;
        logic [SEL2_W-1:0]  sel2;
        logic [SEL3_W-1:0]  sel3;
        logic [SEL6_W-1:0]  sel6;
        logic [SEL9_W-1:0]  sel9;
        logic [SEL11_W-1:0] sel11;
        logic [SEL12_W-1:0] sel12;
        logic [SEL15_W-1:0] sel15;
        logic [SEL17_W-1:0] sel17;
    } step_sel_t;
    function automatic step_sel_t unpack_sel(input logic [SEL_W-1:0] w);
        step_sel_t s;
        s.sel1  = w[SEL1_POS  +: SEL1_W];
        s.sel2  = w[SEL2_POS  +: SEL2_W];
        s.sel3  = w[SEL3_POS  +: SEL3_W];
        s.sel6  = w[SEL6_POS  +: SEL6_W];
        s.sel9  = w[SEL9_POS  +: SEL9_W];
        s.sel11 = w[SEL11_POS +: SEL11_W];
        s.sel12 = w[SEL12_POS +: SEL12_W];
        s.sel15 = w[SEL15_POS +: SEL15_W];
        s.sel17 = w[SEL17_POS +: SEL17_W];
        return s;
    endfunction
endpackage

// File: rtl/test_step_ram.sv
// test_step_ram: DEPTH x W step table, synchronous write, asynchronous read, cleared by reset.
// Ports: clk, rst (sync, active-high), we/waddr/wdata write port, raddr/rdata read port.
module test_step_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 25
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/test_seq_ctrl.sv
// test_seq_ctrl: steps through a table of test-mux select settings with a guard cycle between steps.
// Ports: inClock/inReset (sync, active-high); inWrEn/inWrAddr/inWrData table write (IDLE only);
// inStart/inLastStep/inLoop/inAbort run control; outSEL* registered selects; outBusy, outStep,
// outStepStrobe, outDone, outError status.
module test_seq_ctrl
    import test_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic                     inWrEn,
    input  logic [$clog2(DEPTH)-1:0] inWrAddr,
    input  logic [SEL_W+DWELL_W-1:0] inWrData,
    input  logic [$clog2(DEPTH)-1:0] inLastStep,
    input  logic                     inStart,
    input  logic                     inLoop,
    input  logic                     inAbort,
    output logic [2:0]               outSEL1,
    output logic [2:0]               outSEL2,
    output logic                     outSEL3,
    output logic [1:0]               outSEL6,
    output logic [1:0]               outSEL9,
    output logic                     outSEL11,
    output logic                     outSEL12,
    output logic [2:0]               outSEL15,
    output logic                     outSEL17,
    output logic                     outBusy,
    output logic [$clog2(DEPTH)-1:0] outStep,
    output logic                     outStepStrobe,
    output logic                     outDone,
    output logic                     outError
);
    localparam int AW = $clog2(DEPTH);
    state_t state_q, state_d;
    logic [AW-1:0] step_q, step_d, last_q, last_d;
    logic loop_q, loop_d, strobe_d, err_d, wr_ok;
    logic [DWELL_W-1:0] cnt_q, cnt_d, dwell;
    logic [SEL_W+DWELL_W-1:0] rdata;
    step_sel_t sel_q, sel_d, rd_sel;
    assign wr_ok = inWrEn && state_q == IDLE;
    test_step_ram #(.DEPTH(DEPTH), .W(SEL_W + DWELL_W)) u_ram (
        .clk(inClock), .rst(inReset), .we(wr_ok), .waddr(inWrAddr),
        .wdata(inWrData), .raddr(step_q), .rdata(rdata)
    );
    assign rd_sel = unpack_sel(rdata[SEL_W-1:0]);
    assign dwell  = rdata[SEL_W +: DWELL_W];
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        last_d   = last_q;
        loop_d   = loop_q;
        cnt_d    = cnt_q;
        sel_d    = '0;
        strobe_d = 1'b0;
        err_d    = state_q != IDLE && (inWrEn || inStart);
        if (inAbort) begin
            state_d = IDLE;
            step_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (inStart) begin
                    state_d = GUARD;
                    step_d  = '0;
                    last_d  = inLastStep;
                    loop_d  = inLoop;
                end
                // cnt holds the remaining extra cycles, so dwell=0 and dwell=1 both give one cycle
                GUARD: begin
                    state_d  = DWELL;
                    sel_d    = rd_sel;
                    strobe_d = 1'b1;
                    cnt_d    = (dwell == '0) ? '0 : dwell - 1'b1;
                end
                DWELL: if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    sel_d = sel_q;
                end else if (step_q != last_q) begin
                    step_d  = step_q + 1'b1;
                    state_d = GUARD;
                end else if (loop_q) begin
                    step_d  = '0;
                    state_d = GUARD;
                end else begin
                    state_d = FINISH;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge inClock) begin
        if (inReset) begin
            state_q       <= IDLE;
            step_q        <= '0;
            last_q        <= '0;
            loop_q        <= 1'b0;
            cnt_q         <= '0;
            sel_q         <= '0;
            outStepStrobe <= 1'b0;
            outError      <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            last_q        <= last_d;
            loop_q        <= loop_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            outStepStrobe <= strobe_d;
            outError      <= err_d;
        end
    end
    assign outBusy  = state_q != IDLE;
    assign outDone  = state_q == FINISH;
    assign outStep  = step_q;
    assign outSEL1  = sel_q.sel1;
    assign outSEL2  = sel_q.sel2;
    assign outSEL3  = sel_q.sel3;
    assign outSEL6  = sel_q.sel6;
    assign outSEL9  = sel_q.sel9;
    assign outSEL11 = sel_q.sel11;
    assign outSEL12 = sel_q.sel12;
    assign outSEL15 = sel_q.sel15;
    assign outSEL17 = sel_q.sel17;
endmodule

// File: tb/tb_test_seq_ctrl.sv
// tb_test_seq_ctrl: randomized and directed checks of test_seq_ctrl against a per-run timeline model.
module tb_test_seq_ctrl;
    localparam int DW = 8;
    localparam int EW = 17 + DW;
    typedef struct packed {
        logic        err;
        logic        busy;
        logic        done;
        logic        strobe;
        logic [2:0]  step;
        logic [16:0] sel;
    } rec_t;
    logic clk = 1'b0;
    logic inReset, inWrEn, inStart, inLoop, inAbort;
    logic [2:0] inWrAddr, inLastStep;
    logic [EW-1:0] inWrData;
    logic [2:0] outSEL1, outSEL2, outSEL15, outStep;
    logic [1:0] outSEL6, outSEL9;
    logic outSEL3, outSEL11, outSEL12, outSEL17;
    logic outBusy, outStepStrobe, outDone, outError;
    logic [EW-1:0] tbl [8];
    rec_t q[$];
    int n_chk = 0, n_err = 0, busy_cnt = 0;
    always #5 clk = ~clk;
    test_seq_ctrl #(.DEPTH(8), .DWELL_W(DW)) dut (
        .inClock(clk), .inReset(inReset), .inWrEn(inWrEn), .inWrAddr(inWrAddr),
        .inWrData(inWrData), .inLastStep(inLastStep), .inStart(inStart), .inLoop(inLoop),
        .inAbort(inAbort), .outSEL1(outSEL1), .outSEL2(outSEL2), .outSEL3(outSEL3),
        .outSEL6(outSEL6), .outSEL9(outSEL9), .outSEL11(outSEL11), .outSEL12(outSEL12),
        .outSEL15(outSEL15), .outSEL17(outSEL17), .outBusy(outBusy), .outStep(outStep),
        .outStepStrobe(outStepStrobe), .outDone(outDone), .outError(outError)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    function automatic rec_t obs();
        return rec_t'({outError, outBusy, outDone, outStepStrobe, outStep,
                       outSEL1, outSEL2, outSEL3, outSEL6, outSEL9, outSEL11, outSEL12, outSEL15, outSEL17});
    endfunction
    function automatic rec_t mk(input bit busy, input bit done, input bit strobe, input int step, input logic [16:0] sel);
        return rec_t'({1'b0, busy, done, strobe, 3'(step), sel});
    endfunction
    // Expected cycle-by-cycle timeline of a run, starting the cycle after start is accepted.
    task automatic build(input int last, input bit loop, input int maxlen);
        int s = 0;
        int n;
        q.delete();
        while (!loop || q.size() < maxlen) begin
            q.push_back(mk(1, 0, 0, s, '0));
            n = (tbl[s][EW-1:17] == '0) ? 1 : int'(tbl[s][EW-1:17]);
            for (int j = 0; j < n; j++) q.push_back(mk(1, 0, j == 0, s, tbl[s][16:0]));
            if (s == last) begin
                if (!loop) begin
                    q.push_back(mk(1, 1, 0, s, '0));
                    q.push_back(mk(0, 0, 0, 0, '0));
                    return;
                end
                s = 0;
            end else begin
                s++;
            end
        end
    endtask
    task automatic wr_entry(input int a, input logic [EW-1:0] d);
        @(negedge clk);
        inWrEn = 1'b1;
        inWrAddr = 3'(a);
        inWrData = d;
        tbl[a] = d;
        @(negedge clk);
        inWrEn = 1'b0;
        check("wr_err", 32'(outError), 32'(0));
    endtask
    // ab/rs: record index after which abort/reset is pulsed; wr/st: index at which a busy write/start is driven.
    task automatic run(input int last, input bit loop, input int maxlen, input int ab, input int wr, input int st, input int rs);
        rec_t e, o;
        build(last, loop, maxlen);
        if (ab >= q.size()) ab = -1;
        if (loop && ab < 0) ab = q.size() - 1;
        if (rs >= q.size() - 1) rs = -1;
        if (wr >= q.size() - 1 || wr == ab || wr == rs) wr = -1;
        if (st >= q.size() - 1 || st == ab || st == rs) st = -1;
        busy_cnt = 0;
        @(negedge clk);
        inStart = 1'b1;
        inLastStep = 3'(last);
        inLoop = loop;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            inStart = 1'b0;
            inWrEn = 1'b0;
            inLoop = 1'($urandom);
            inLastStep = 3'($urandom);
            e = q[i];
            e.err = i > 0 && (i - 1 == wr || i - 1 == st);
            o = obs();
            if (!e.busy) begin
                e.step = '0;
                o.step = '0;
            end
            check("trace", 32'(o), 32'(e));
            busy_cnt += int'(outBusy);
            if (i == ab || i == rs) begin
                if (i == ab) inAbort = 1'b1;
                else inReset = 1'b1;
                @(negedge clk);
                inAbort = 1'b0;
                inReset = 1'b0;
                check(i == ab ? "abort_outs" : "rst_outs", 32'(obs()), 32'(0));
                if (i == rs) foreach (tbl[k]) tbl[k] = '0;
                return;
            end
            if (i == wr) begin
                inWrEn = 1'b1;
                inWrAddr = 3'($urandom);
                inWrData = EW'($urandom);
            end
            if (i == st) inStart = 1'b1;
        end
        inStart = 1'b0;
        inWrEn = 1'b0;
    endtask
    initial begin
        bit lp;
        inReset = 1'b1;
        inWrEn = 1'b0;
        inStart = 1'b0;
        inLoop = 1'b0;
        inAbort = 1'b0;
        inWrAddr = '0;
        inWrData = '0;
        inLastStep = '0;
        foreach (tbl[k]) tbl[k] = '0;
        repeat (2) @(negedge clk);
        check("reset", 32'(obs()), 32'(0));
        inReset = 1'b0;
        wr_entry(0, {8'd3, 3'd5, 14'd0});
        wr_entry(1, {8'd0, 9'd0, 2'd2, 6'd0});
        run(1, 0, 0, -1, -1, -1, -1);
        run(1, 1, 16, 14, -1, -1, -1);
        run(1, 0, 0, -1, 2, 4, -1);
        run(1, 0, 0, -1, -1, -1, -1);
        @(negedge clk);
        inStart = 1'b1;
        inAbort = 1'b1;
        @(negedge clk);
        inStart = 1'b0;
        inAbort = 1'b0;
        check("sa_busy", 32'(outBusy), 32'(0));
        check("sa_err", 32'(outError), 32'(0));
        @(negedge clk);
        check("sa_busy2", 32'(outBusy), 32'(0));
        run(1, 0, 0, -1, -1, -1, 2);
        run(3, 0, 0, -1, -1, -1, -1);
        repeat (25) begin
            for (int a = 0; a < 8; a++)
                if ($urandom_range(1, 0) == 1) wr_entry(a, {DW'($urandom_range(4, 0)), 17'($urandom)});
            lp = 1'($urandom_range(1, 0));
            run($urandom_range(7, 0), lp, $urandom_range(40, 8),
                (lp || $urandom_range(3, 0) == 0) ? $urandom_range(40, 3) : -1,
                $urandom_range(1, 0) == 1 ? $urandom_range(20, 0) : -1,
                $urandom_range(1, 0) == 1 ? $urandom_range(20, 0) : -1, -1);
        end
        for (int a = 0; a < 8; a++) wr_entry(a, {8'd255, 17'($urandom)});
        run(7, 0, 0, -1, -1, -1, -1);
        check("busy_cycles", 32'(busy_cnt), 32'(2049));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
